// File: rtl/char_rom_arbiter.sv
// Shares the single-port char_rom among text-line builders: grants one requester per cycle
// and returns each ROM byte through a tagged pipeline. `CHARARB_FIXED_PRIO_EN selects fixed priority.
module char_rom_arbiter #(
  parameter int unsigned NUM_REQ     = 3,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ROM_LATENCY = 1
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             line_start,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  output logic [NUM_REQ-1:0]               grant,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic [ADDR_WIDTH-1:0]            rom_addr,
  input  logic [DATA_WIDTH-1:0]            rom_q,
  output logic [15:0]                      accept_count
);

  localparam int unsigned PTR_WIDTH  = $clog2(NUM_REQ);
  localparam int unsigned TAG_STAGES = ROM_LATENCY + 1;

  logic                  found;
  logic [PTR_WIDTH-1:0]  grant_idx;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [NUM_REQ-1:0]    tag_pipe [TAG_STAGES];

`ifdef CHARARB_FIXED_PRIO_EN
  logic unused_line_start;
  assign unused_line_start = line_start;

  // Lowest asserted index wins.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        found     = 1'b1;
        grant_idx = PTR_WIDTH'(i);
      end
    end
    grant = (found && reset_n) ? (NUM_REQ'(1) << grant_idx) : '0;
  end
`else
  logic [PTR_WIDTH-1:0] rr_ptr;
  logic [PTR_WIDTH-1:0] rr_ptr_next;
  logic [NUM_REQ-1:0]   req_rot;
  int                   sum;

  // Rotate req so bit 0 is the pointer position, then take the first set bit.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    sum       = 0;
    req_rot   = NUM_REQ'({req, req} >> rr_ptr);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_rot[i]) begin
        found = 1'b1;
        sum   = int'(rr_ptr) + i;
        if (sum >= int'(NUM_REQ)) sum = sum - int'(NUM_REQ);
        grant_idx = PTR_WIDTH'(sum);
      end
    end
    grant = (found && reset_n) ? (NUM_REQ'(1) << grant_idx) : '0;
  end

  always_comb begin
    rr_ptr_next = rr_ptr;
    if (line_start) begin
      rr_ptr_next = '0;
    end else if (accept) begin
      rr_ptr_next = (grant_idx == PTR_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) rr_ptr <= '0;
    else          rr_ptr <= rr_ptr_next;
  end
`endif

  assign accept = |(req & grant);

  // Address of the granted requester.
  always_comb begin
    addr_sel = rom_addr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) addr_sel = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // ROM address, tag pipeline and response stage; rsp_valid lines up with rsp_data.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rom_addr     <= '0;
      accept_count <= '0;
      rsp_valid    <= '0;
      rsp_data     <= '0;
      for (int i = 0; i < int'(TAG_STAGES); i++) tag_pipe[i] <= '0;
    end else begin
      if (accept) begin
        rom_addr     <= addr_sel;
        accept_count <= accept_count + 16'd1;
      end
      tag_pipe[0] <= accept ? grant : '0;
      for (int i = 1; i < int'(TAG_STAGES); i++) tag_pipe[i] <= tag_pipe[i-1];
      rsp_valid <= tag_pipe[TAG_STAGES-1];
      rsp_data  <= rom_q;
    end
  end

endmodule

// File: tb/tb_char_rom_arbiter.sv
// Directed bench for char_rom_arbiter with a latency-1 ROM model returning addr ^ 0xFF.
module tb_char_rom_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        line_start = 1'b0;
  logic [2:0]  req = '0;
  logic [23:0] req_addr = '0;
  logic [2:0]  grant;
  logic [2:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_q = '0;
  logic [15:0] accept_count;

  int checks = 0;
  int errors = 0;

  char_rom_arbiter dut (
    .clock(clock), .reset_n(reset_n), .line_start(line_start), .req(req),
    .req_addr(req_addr), .grant(grant), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rom_addr(rom_addr), .rom_q(rom_q), .accept_count(accept_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) rom_q <= rom_addr ^ 8'hFF;

  task automatic do_reset();
    reset_n = 1'b0; req = '0; line_start = 1'b0; req_addr = '0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = 3'b111; line_start = 1'b0;
    #1;
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL reset_grant got %b want 000", grant); end
    @(negedge clock);
    checks++; if (rsp_valid !== 3'b000) begin errors++; $display("FAIL reset_rsp_valid got %b want 000", rsp_valid); end
    checks++; if (rom_addr !== 8'h00) begin errors++; $display("FAIL reset_rom_addr got %h want 00", rom_addr); end
    checks++; if (accept_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", accept_count); end
    checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_data got %h want 00", rsp_data); end
    reset_n = 1'b1;
    #1;
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL reset_first_grant got %b want 001", grant); end
    req = '0;
    @(negedge clock);
  endtask

  task automatic test_single();
    do_reset();
    req = 3'b010; req_addr = {8'h00, 8'h35, 8'h00};
    #1;
    checks++; if (grant !== 3'b010) begin errors++; $display("FAIL single_grant got %b want 010", grant); end
    @(negedge clock);
    req = '0;
    checks++; if (rom_addr !== 8'h35) begin errors++; $display("FAIL single_rom_addr got %h want 35", rom_addr); end
    checks++; if (rsp_valid !== 3'b000) begin errors++; $display("FAIL single_early1 got %b want 000", rsp_valid); end
    @(negedge clock);
    checks++; if (rsp_valid !== 3'b000) begin errors++; $display("FAIL single_early2 got %b want 000", rsp_valid); end
    @(negedge clock);
    checks++; if (rsp_valid !== 3'b010) begin errors++; $display("FAIL single_rsp_valid got %b want 010", rsp_valid); end
    checks++; if (rsp_data !== 8'hCA) begin errors++; $display("FAIL single_rsp_data got %h want ca", rsp_data); end
    checks++; if (accept_count !== 16'd1) begin errors++; $display("FAIL single_count got %0d want 1", accept_count); end
    @(negedge clock);
    checks++; if (rsp_valid !== 3'b000) begin errors++; $display("FAIL single_late got %b want 000", rsp_valid); end
  endtask

  task automatic test_contention();
    int gseq [6] = '{0, 1, 2, 0, 1, 2};
    logic [2:0] eg;
    logic [7:0] ed;
    do_reset();
    req_addr = {8'h30, 8'h20, 8'h10};
    for (int c = 0; c < 10; c++) begin
      req = (c < 6) ? 3'b111 : 3'b000;
      #1;
      if (c < 6) begin
        eg = 3'b001 << gseq[c];
        checks++; if (grant !== eg) begin errors++; $display("FAIL contention_grant c=%0d got %b want %b", c, grant, eg); end
      end
      if (c >= 3 && c < 9) begin
        eg = 3'b001 << gseq[c-3];
        ed = 8'((gseq[c-3] + 1) * 16) ^ 8'hFF;
        checks++; if (rsp_valid !== eg) begin errors++; $display("FAIL contention_rsp c=%0d got %b want %b", c, rsp_valid, eg); end
        checks++; if (rsp_data !== ed) begin errors++; $display("FAIL contention_data c=%0d got %h want %h", c, rsp_data, ed); end
      end else begin
        checks++; if (rsp_valid !== 3'b000) begin errors++; $display("FAIL contention_idle c=%0d got %b want 000", c, rsp_valid); end
      end
      @(negedge clock);
    end
    checks++; if (accept_count !== 16'd6) begin errors++; $display("FAIL contention_count got %0d want 6", accept_count); end
  endtask

  task automatic test_line_start();
    logic [2:0] gexp [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b001, 3'b010};
    do_reset();
    req_addr = {8'h03, 8'h02, 8'h01};
    for (int c = 0; c < 6; c++) begin
      req = 3'b111;
      line_start = (c == 2 || c == 3);
      #1;
      checks++; if (grant !== gexp[c]) begin errors++; $display("FAIL line_start_grant c=%0d got %b want %b", c, grant, gexp[c]); end
      if (c == 5) begin
        checks++; if (rsp_valid !== 3'b100) begin errors++; $display("FAIL line_start_rsp got %b want 100", rsp_valid); end
        checks++; if (rsp_data !== 8'hFC) begin errors++; $display("FAIL line_start_data got %h want fc", rsp_data); end
        checks++; if (accept_count !== 16'd5) begin errors++; $display("FAIL line_start_count got %0d want 5", accept_count); end
      end
      @(negedge clock);
    end
    req = '0; line_start = 1'b0;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    req = 3'b100; req_addr = {8'h77, 8'h00, 8'h00};
    #1;
    checks++; if (grant !== 3'b100) begin errors++; $display("FAIL midrst_grant got %b want 100", grant); end
    @(negedge clock);
    req = 3'b111; reset_n = 1'b0;
    #1;
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL midrst_grant_in_reset got %b want 000", grant); end
    @(negedge clock);
    reset_n = 1'b1; req = '0;
    checks++; if (rom_addr !== 8'h00) begin errors++; $display("FAIL midrst_rom_addr got %h want 00", rom_addr); end
    checks++; if (accept_count !== 16'd0) begin errors++; $display("FAIL midrst_count got %0d want 0", accept_count); end
    for (int c = 0; c < 3; c++) begin
      checks++; if (rsp_valid !== 3'b000) begin errors++; $display("FAIL midrst_rsp c=%0d got %b want 000", c, rsp_valid); end
      @(negedge clock);
    end
    req = 3'b111;
    #1;
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL midrst_next_grant got %b want 001", grant); end
    req = '0;
    @(negedge clock);
  endtask

  task automatic test_withdrawal();
    do_reset();
    req_addr = {8'h0C, 8'h0B, 8'h0A};
    req = 3'b010;
    #1;
    checks++; if (grant !== 3'b010) begin errors++; $display("FAIL withdraw_pre_grant got %b want 010", grant); end
    @(negedge clock);
    req = 3'b101;
    #1;
    checks++; if (grant !== 3'b100) begin errors++; $display("FAIL withdraw_grant got %b want 100", grant); end
    @(negedge clock);
    req = '0;
    for (int c = 2; c < 7; c++) begin
      checks++; if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL withdraw_rsp0 c=%0d got %b want 0", c, rsp_valid[0]); end
      if (c == 4) begin
        checks++; if (rsp_valid !== 3'b100) begin errors++; $display("FAIL withdraw_rsp2 got %b want 100", rsp_valid); end
        checks++; if (rsp_data !== 8'hF3) begin errors++; $display("FAIL withdraw_data got %h want f3", rsp_data); end
      end
      @(negedge clock);
    end
    checks++; if (accept_count !== 16'd2) begin errors++; $display("FAIL withdraw_count got %0d want 2", accept_count); end
  endtask

  task automatic test_fixed_prio();
    do_reset();
    req_addr = {8'h03, 8'h02, 8'h01};
    for (int c = 0; c < 4; c++) begin
      req = 3'b111;
      line_start = (c == 1);
      #1;
      checks++; if (grant !== 3'b001) begin errors++; $display("FAIL fixed_grant c=%0d got %b want 001", c, grant); end
      @(negedge clock);
    end
    req = 3'b110; line_start = 1'b0;
    #1;
    checks++; if (grant !== 3'b010) begin errors++; $display("FAIL fixed_next_grant got %b want 010", grant); end
    @(negedge clock);
    req = '0;
    checks++; if (accept_count !== 16'd5) begin errors++; $display("FAIL fixed_count got %0d want 5", accept_count); end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_single();
    test_reset_midflight();
`ifdef CHARARB_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_contention();
    test_line_start();
    test_withdrawal();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/char_rom_arbiter.md
# char_rom_arbiter

Shares one single-port `char_rom` glyph ROM among several text-line builders: the lag-display digit writer, the resolution line, and future overlays. Each requester presents a glyph-row address with a valid/grant handshake. The arbiter grants one requester per cycle, drives the ROM address, and returns the ROM byte to the granted requester through a fixed-latency tagged pipeline. It sits in `source/video` between the line builders and the ROM.

## Interface
Parameters:
- `NUM_REQ`, 3: number of requesters (2..8).
- `ADDR_WIDTH`, 8: ROM address width.
- `DATA_WIDTH`, 8: ROM data width (one glyph row).
- `ROM_LATENCY`, 1: clock edges from `rom_addr` to valid `rom_q` (1..3).

Ports:
- `clock` in 1: pixel clock.
- `reset_n` in 1: synchronous, active-low reset.
- `line_start` in 1: one-cycle pulse at `counterX == 0`; resets the arbitration pointer.
- `req` in NUM_REQ: per-requester read request; held, with its address stable, until granted.
- `req_addr` in NUM_REQ*ADDR_WIDTH: requester i address at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `grant` out NUM_REQ: one-hot combinational grant; `req[i] && grant[i]` at a rising edge is an accept.
- `rsp_valid` out NUM_REQ: one-hot, registered; marks the response cycle for requester i.
- `rsp_data` out DATA_WIDTH: registered ROM byte, shared; qualified by `rsp_valid`.
- `rom_addr` out ADDR_WIDTH: registered address to `char_rom`.
- `rom_q` in DATA_WIDTH: `char_rom` output.
- `accept_count` out 16: accepts since reset, wrapping at 0xFFFF→0.

## Operation
- Arbitration is combinational from `req` and the pointer `rr_ptr` (log2(NUM_REQ) bits, reset 0).
  - Search indices `rr_ptr, rr_ptr+1, …` modulo NUM_REQ; grant the first asserted `req`.
  - No `req` set: `grant = 0`.
  - `grant` is forced to 0 while `reset_n` is low.
- On accept of index k:
  - `rom_addr <= req_addr[k]`.
  - Push one-hot k into the tag pipeline, depth ROM_LATENCY+1.
  - `rr_ptr <= (k+1) mod NUM_REQ`.
  - `accept_count` increments.
- No accept: `rom_addr` holds, a zero tag is pushed, and `rr_ptr` holds.
- Response stage, every edge: `rsp_data <= rom_q`, `rsp_valid <=` tag pipeline output. `rsp_data` updates every cycle; it is meaningful only when `rsp_valid` is nonzero.
- `line_start`:
  - Sets `rr_ptr <= 0`. This overrides the pointer advance from a simultaneous accept.
  - The accept itself still completes normally.
- A requester may drop `req` or present a new address in the cycle after its accept. Back-to-back accepts of the same requester are legal when it is the only one requesting.
- `req` deasserted before grant: the request is withdrawn with no side effects. This is legal.
- Reset, including mid-operation:
  - `rr_ptr = 0`, `rom_addr = 0`, the tag pipeline is cleared, `rsp_valid = 0`, `rsp_data = 0`, `accept_count = 0`.
  - In-flight reads are discarded and never produce `rsp_valid`.

## Timing
- Throughput: one accept per cycle.
- Latency: accept at edge E0 → `rom_addr` valid after E0 → `rom_q` valid after E0+ROM_LATENCY → `rsp_valid`/`rsp_data` valid after E0+ROM_LATENCY+1. With the default, the response arrives 2 edges after the accept.
- Responses return in accept order; at most one `rsp_valid` bit is set per cycle.
- `grant` depends combinationally on `req`. Requesters must not derive `req` combinationally from `grant`.
- Starvation bound: with all requesters continuously requesting, each is granted within NUM_REQ cycles. A `line_start` pulse may restart the sequence at index 0.

## Configuration
- `CHARARB_FIXED_PRIO_EN`
  - Defined: strict fixed priority, lowest index wins. `rr_ptr` is not implemented, and `line_start` has no effect on arbitration.
  - Undefined (default): round-robin as described above.
  - Latency, response pipeline and `accept_count` are identical in both builds.

## Test plan
- Single requester: `req[1]=1`, addr 0x35 held 1 cycle, `rom_q` model = addr^0xFF → `grant=3'b010` in that cycle; 2 edges later `rsp_valid=3'b010`, `rsp_data=0xCA`; `accept_count=1`.
- Full contention: all three `req` held 6 cycles with addrs 0x10/0x20/0x30 → grants in order 0,1,2,0,1,2; `rsp_valid` follows the same order 2 cycles later with matching data.
- line_start: after granting 0 and 1 with all requesting, pulse `line_start` in the same cycle as the grant of 2 → that accept completes, and the next grant is 0, not 0-after-2 ordering.
- Reset mid-flight: accept for requester 2, assert `reset_n=0` on the next edge for 1 cycle → `rsp_valid` stays 0, `rom_addr=0`, `accept_count=0`, the next grant goes to index 0.
- Withdrawal: `req[0]` high 1 cycle while `req[2]` is granted, then low → no `rsp_valid[0]` ever; `accept_count` counts only requester 2.
- Fixed priority (`CHARARB_FIXED_PRIO_EN` defined): all `req` held 4 cycles → grants 0,0,0,0; requester 0 dropped → next grant 1.
